// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel strobe, H/V sync, data enable, markers and frame counter.
// Outputs are registered and lag the internal hc/vc counters by one pixel; stopping only happens at a frame boundary.
module vga_timing_gen #(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CW         = 10,
  parameter int FCW        = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  output logic           busy,
  output logic           pix_stb,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [CW-1:0]  pixel_x,
  output logic [CW-1:0]  pixel_y,
  output logic           line_start,
  output logic           frame_start,
  output logic           frame_end,
  output logic [FCW-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW:0]   H_ACT_W  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0]   V_ACT_W  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0]   HS_BEG   = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0]   HS_END   = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0]   VS_BEG   = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0]   VS_END   = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          go_idle;
  logic [DW-1:0] div;
  logic [CW-1:0] hc;
  logic [CW-1:0] vc;
  logic [CW:0]   hc_w;
  logic [CW:0]   vc_w;
  logic          h_last;
  logic          v_last;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // frame_end is high for the single clock after the last pixel loads, which is the stop point.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (en) state_nxt = RUN;
      RUN:      if (!en) state_nxt = STOPPING;
      STOPPING: begin
        if (en)             state_nxt = RUN;
        else if (frame_end) state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    go_idle = (state == STOPPING) && (state_nxt == IDLE);
  end

  assign hc_w   = {1'b0, hc};
  assign vc_w   = {1'b0, vc};
  assign h_last = (hc == H_LAST);
  assign v_last = (vc == V_LAST);

  always_ff @(posedge clk) begin
    if (reset || state == IDLE || go_idle) begin
      div         <= '0;
      hc          <= '0;
      vc          <= '0;
      pix_stb     <= 1'b0;
      de          <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      hsync       <= ~H_SYNC_POL;
      vsync       <= ~V_SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      if (reset) frame_count <= '0;
    end else begin
      div         <= (div == DIV_LAST) ? '0 : div + DW'(1);
      pix_stb     <= (div == DIV_LAST);
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      if (pix_stb) begin
        pixel_x     <= hc;
        pixel_y     <= vc;
        de          <= (hc_w < H_ACT_W) && (vc_w < V_ACT_W);
        hsync       <= ((hc_w >= HS_BEG) && (hc_w < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
        vsync       <= ((vc_w >= VS_BEG) && (vc_w < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
        line_start  <= (hc == '0);
        frame_start <= (hc == '0) && (vc == '0);
        frame_end   <= h_last && v_last;
        if (h_last && v_last) frame_count <= frame_count + FCW'(1);
        if (h_last) begin
          hc <= '0;
          vc <= v_last ? '0 : vc + CW'(1);
        end else begin
          hc <= hc + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default, medium and small configurations driven side by side.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default configuration
  logic d_rst, d_en, d_busy, d_stb, d_hs, d_vs, d_de, d_ls, d_fs, d_fe;
  logic [9:0] d_x, d_y;
  logic [15:0] d_fc;
  vga_timing_gen dut_d (
    .clk(clk), .reset(d_rst), .en(d_en), .busy(d_busy), .pix_stb(d_stb),
    .hsync(d_hs), .vsync(d_vs), .de(d_de), .pixel_x(d_x), .pixel_y(d_y),
    .line_start(d_ls), .frame_start(d_fs), .frame_end(d_fe), .frame_count(d_fc));

  // medium configuration: 24x15 raster, 720 clocks per frame
  logic m_rst, m_en, m_busy, m_stb, m_hs, m_vs, m_de, m_ls, m_fs, m_fe;
  logic [5:0] m_x, m_y;
  logic [7:0] m_fc;
  vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .CW(6), .FCW(8)) dut_m (
    .clk(clk), .reset(m_rst), .en(m_en), .busy(m_busy), .pix_stb(m_stb),
    .hsync(m_hs), .vsync(m_vs), .de(m_de), .pixel_x(m_x), .pixel_y(m_y),
    .line_start(m_ls), .frame_start(m_fs), .frame_end(m_fe), .frame_count(m_fc));

  // small configuration: 7x5 raster, positive hsync, 2-bit frame counter
  logic s_rst, s_en, s_busy, s_stb, s_hs, s_vs, s_de, s_ls, s_fs, s_fe;
  logic [3:0] s_x, s_y;
  logic [1:0] s_fc;
  vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
                   .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_SYNC_POL(1'b1),
                   .CW(4), .FCW(2)) dut_s (
    .clk(clk), .reset(s_rst), .en(s_en), .busy(s_busy), .pix_stb(s_stb),
    .hsync(s_hs), .vsync(s_vs), .de(s_de), .pixel_x(s_x), .pixel_y(s_y),
    .line_start(s_ls), .frame_start(s_fs), .frame_end(s_fe), .frame_count(s_fc));

  task automatic test_reset();
    d_rst = 1; m_rst = 1; s_rst = 1; d_en = 0; m_en = 0; s_en = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({d_busy, d_stb, d_de, d_ls, d_fs, d_fe} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b want 000000", {d_busy, d_stb, d_de, d_ls, d_fs, d_fe});
    end
    checks++;
    if ({d_hs, d_vs} !== 2'b11) begin
      errors++; $display("FAIL reset_syncs got %b want 11", {d_hs, d_vs});
    end
    checks++;
    if (d_x !== 10'd0 || d_y !== 10'd0) begin
      errors++; $display("FAIL reset_xy got (%0d,%0d) want (0,0)", d_x, d_y);
    end
    checks++;
    if (d_fc !== 16'd0) begin
      errors++; $display("FAIL reset_fc got %0d want 0", d_fc);
    end
    checks++;
    if ({s_hs, s_vs} !== 2'b01) begin
      errors++; $display("FAIL reset_small_syncs got %b want 01", {s_hs, s_vs});
    end
  endtask

  task automatic test_first_strobe();
    logic seen;
    d_rst = 0; d_en = 1;
    @(negedge clk);
    checks++;
    if (d_busy !== 1'b1) begin
      errors++; $display("FAIL start_busy got %b want 1", d_busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (d_stb !== 1'b0) begin
      errors++; $display("FAIL early_stb got %b want 0", d_stb);
    end
    @(negedge clk);
    checks++;
    if (d_stb !== 1'b1) begin
      errors++; $display("FAIL first_stb got %b want 1", d_stb);
    end
    @(negedge clk);
    checks++;
    if ({d_fs, d_ls, d_de, d_hs, d_stb} !== 5'b11110 || d_x !== 10'd0 || d_y !== 10'd0) begin
      errors++; $display("FAIL first_pixel got fs/ls/de/hs/stb=%b (%0d,%0d) want 11110 (0,0)",
                         {d_fs, d_ls, d_de, d_hs, d_stb}, d_x, d_y);
    end
    seen = 0;
    repeat (2) begin @(negedge clk); seen |= d_stb; end
    @(negedge clk);
    checks++;
    if (seen !== 1'b0 || d_stb !== 1'b1) begin
      errors++; $display("FAIL stb_period got between=%b at4=%b want 0,1", seen, d_stb);
    end
  endtask

  task automatic test_hsync_line();
    int n, cyc, de_cyc, hs_cyc, hs_x;
    n = 0;
    while (!d_ls && n < 5000) begin @(negedge clk); n++; end
    checks++;
    if (!d_ls) begin
      errors++; $display("FAIL line_start_timeout got 0 want 1");
    end
    cyc = 0; de_cyc = 0; hs_cyc = 0; hs_x = -1;
    do begin
      if (d_de) de_cyc++;
      if (!d_hs) begin
        hs_cyc++;
        if (hs_x < 0) hs_x = int'(d_x);
      end
      @(negedge clk); cyc++;
    end while (!d_ls && cyc < 5000);
    checks++;
    if (cyc != 3200) begin
      errors++; $display("FAIL line_period got %0d want 3200", cyc);
    end
    checks++;
    if (de_cyc != 2560) begin
      errors++; $display("FAIL de_clocks got %0d want 2560", de_cyc);
    end
    checks++;
    if (hs_cyc != 384) begin
      errors++; $display("FAIL hsync_clocks got %0d want 384", hs_cyc);
    end
    checks++;
    if (hs_x != 656) begin
      errors++; $display("FAIL hsync_first_x got %0d want 656", hs_x);
    end
    d_rst = 1;
  endtask

  task automatic test_vsync_frame();
    int n, cyc, vs_cyc, vs_y;
    m_rst = 0; m_en = 1;
    n = 0;
    while (!m_fs && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!m_fs || m_fc !== 8'd0) begin
      errors++; $display("FAIL m_frame_start got fs=%b fc=%0d want 1,0", m_fs, m_fc);
    end
    cyc = 0; vs_cyc = 0; vs_y = -1;
    while (!m_fe && cyc < 2000) begin
      if (!m_vs) begin
        vs_cyc++;
        if (vs_y < 0) vs_y = int'(m_y);
      end
      @(negedge clk); cyc++;
    end
    checks++;
    if (cyc != 718) begin
      errors++; $display("FAIL frame_span got %0d want 718", cyc);
    end
    checks++;
    if (vs_cyc != 96 || vs_y != 10) begin
      errors++; $display("FAIL vsync got clocks=%0d first_y=%0d want 96,10", vs_cyc, vs_y);
    end
    checks++;
    if (m_fc !== 8'd1 || m_x !== 6'd23 || m_y !== 6'd14) begin
      errors++; $display("FAIL frame_end_state got fc=%0d (%0d,%0d) want 1 (23,14)", m_fc, m_x, m_y);
    end
  endtask

  task automatic test_en_drop();
    int n;
    logic seen;
    n = 0;
    while (!(m_x == 6'd5 && m_y == 6'd3) && n < 800) begin @(negedge clk); n++; end
    m_en = 0;
    n = 0;
    while (!m_fe && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (!m_fe || m_busy !== 1'b1 || m_x !== 6'd23 || m_y !== 6'd14 || m_fc !== 8'd2) begin
      errors++; $display("FAIL drop_complete got fe=%b busy=%b (%0d,%0d) fc=%0d want 1,1 (23,14) 2",
                         m_fe, m_busy, m_x, m_y, m_fc);
    end
    @(negedge clk);
    checks++;
    if ({m_busy, m_hs, m_vs, m_de} !== 4'b0110 || m_x !== 6'd0 || m_y !== 6'd0 || m_fc !== 8'd2) begin
      errors++; $display("FAIL drop_idle got busy/hs/vs/de=%b (%0d,%0d) fc=%0d want 0110 (0,0) 2",
                         {m_busy, m_hs, m_vs, m_de}, m_x, m_y, m_fc);
    end
    seen = 0;
    repeat (10) begin @(negedge clk); seen |= m_stb | m_busy; end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL idle_quiet got %b want 0", seen);
    end
  endtask

  task automatic test_en_toggle();
    int n, changes;
    logic busy_low;
    logic [5:0] px, py, ex, ey;
    m_en = 1;
    n = 0;
    while (!m_fs && n < 100) begin @(negedge clk); n++; end
    px = m_x; py = m_y; changes = 0; busy_low = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 20) m_en = 0;
      if (i == 23) m_en = 1;
      busy_low |= ~m_busy;
      if (m_x !== px || m_y !== py) begin
        changes++;
        ex = (px == 6'd23) ? 6'd0 : px + 6'd1;
        ey = (px == 6'd23) ? ((py == 6'd14) ? 6'd0 : py + 6'd1) : py;
        checks++;
        if (m_x !== ex || m_y !== ey) begin
          errors++; $display("FAIL toggle_seq got (%0d,%0d) want (%0d,%0d)", m_x, m_y, ex, ey);
        end
        px = m_x; py = m_y;
      end
    end
    checks++;
    if (changes != 100 || busy_low !== 1'b0) begin
      errors++; $display("FAIL toggle_gap got changes=%0d busy_low=%b want 100,0", changes, busy_low);
    end
  endtask

  task automatic test_final_strobe_stop();
    int n;
    n = 0;
    while (!(m_x == 6'd22 && m_y == 6'd14 && m_stb) && n < 1000) begin @(negedge clk); n++; end
    m_en = 0;
    @(negedge clk);
    checks++;
    if (!m_fe || m_busy !== 1'b1 || m_x !== 6'd23 || m_y !== 6'd14 || m_fc !== 8'd3) begin
      errors++; $display("FAIL late_drop_end got fe=%b busy=%b (%0d,%0d) fc=%0d want 1,1 (23,14) 3",
                         m_fe, m_busy, m_x, m_y, m_fc);
    end
    @(negedge clk);
    checks++;
    if (m_busy !== 1'b0 || m_x !== 6'd0) begin
      errors++; $display("FAIL late_drop_idle got busy=%b x=%0d want 0,0", m_busy, m_x);
    end
  endtask

  task automatic test_small_frames();
    int n;
    logic [1:0] exp_fc;
    s_rst = 0; s_en = 1;
    n = 0;
    while (s_x != 4'd5 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (s_x !== 4'd5 || s_hs !== 1'b1) begin
      errors++; $display("FAIL small_hsync_x5 got x=%0d hs=%b want 5,1", s_x, s_hs);
    end
    n = 0;
    while (s_x != 4'd6 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (s_x !== 4'd6 || s_hs !== 1'b0) begin
      errors++; $display("FAIL small_hsync_x6 got x=%0d hs=%b want 6,0", s_x, s_hs);
    end
    for (int f = 0; f < 5; f++) begin
      n = 0;
      while (!s_fe && n < 200) begin @(negedge clk); n++; end
      exp_fc = 2'(f + 1);
      checks++;
      if (!s_fe || s_fc !== exp_fc) begin
        errors++; $display("FAIL small_fc frame %0d got fe=%b fc=%0d want 1,%0d", f, s_fe, s_fc, exp_fc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    logic seen;
    n = 0;
    while (!(s_x == 4'd3 && s_y == 4'd1) && n < 200) begin @(negedge clk); n++; end
    s_rst = 1; s_en = 0;
    @(negedge clk);
    checks++;
    if ({s_busy, s_stb, s_hs, s_vs, s_de, s_ls, s_fs, s_fe} !== 8'b00010000 ||
        s_x !== 4'd0 || s_y !== 4'd0 || s_fc !== 2'd0) begin
      errors++; $display("FAIL midframe_reset got flags=%b (%0d,%0d) fc=%0d want 00010000 (0,0) 0",
                         {s_busy, s_stb, s_hs, s_vs, s_de, s_ls, s_fs, s_fe}, s_x, s_y, s_fc);
    end
    s_rst = 0; s_en = 1;
    seen = 0;
    repeat (3) begin @(negedge clk); seen |= s_fs; end
    @(negedge clk);
    checks++;
    if (seen !== 1'b0 || {s_fs, s_ls} !== 2'b11 || s_x !== 4'd0 || s_y !== 4'd0) begin
      errors++; $display("FAIL restart got early=%b fs/ls=%b (%0d,%0d) want 0,11 (0,0)",
                         seen, {s_fs, s_ls}, s_x, s_y);
    end
  endtask

  initial begin
    d_rst = 1; m_rst = 1; s_rst = 1; d_en = 0; m_en = 0; s_en = 0;
    test_reset();
    test_first_strobe();
    test_hsync_line();
    test_vsync_frame();
    test_en_drop();
    test_en_toggle();
    test_final_strobe_stop();
    test_small_frames();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
